tpu_slot_timer: RTL and testbench

//  Free-running TDMA frame timer for the TPU. Produces the 16-bit slot/tick counter consumed
//  by the slot clock gater: [15:9] = slot index, [8:0] = tick within the slot.

---
 rtl/tpu_slot_timer_pkg.sv | 20 ++
 rtl/tpu_slot_timer_if.sv | 37 +++
 rtl/tpu_slot_timer.sv | 96 +++++++++
 tb/tb_tpu_slot_timer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_slot_timer_pkg.sv
// Shared types and constants for the TPU TDMA slot/frame timer.
// TPU_SLOT_LIMIT_EN (when defined) adds a programmable last-slot index.
package tpu_timer_pkg;

    localparam int SLOT_W = 7;
    localparam int TICK_W = 9;
    localparam int CNT_W  = SLOT_W + TICK_W;

    typedef enum logic [1:0] {
        TMR_IDLE,
        TMR_RUN,
        TMR_PAUSE
    } tmr_state_e;

    localparam int CTL_RSTTPU = 0;
    localparam int CTL_TXEN   = 1;
    localparam int CTL_RXEN   = 2;
    localparam int CTL_INTMSK = 3;

endpackage

// File: rtl/tpu_slot_timer_if.sv
// Control/status bundle between the register file and the slot timer.
// TPU_SLOT_LIMIT_EN adds the num_slots field.
interface tpu_slot_timer_if;
    import tpu_timer_pkg::*;

    logic [7:0]       tpu_control;
    logic             int_clr;
`ifdef TPU_SLOT_LIMIT_EN
    logic [SLOT_W-1:0] num_slots;
`endif
    logic [CNT_W-1:0] counter;
    logic             slot_start;
    logic             frame_wrap;
    logic             int_flag;
    logic             tpu_irq;

`ifdef TPU_SLOT_LIMIT_EN
    modport master (
        output tpu_control, int_clr, num_slots,
        input  counter, slot_start, frame_wrap, int_flag, tpu_irq
    );
    modport slave (
        input  tpu_control, int_clr, num_slots,
        output counter, slot_start, frame_wrap, int_flag, tpu_irq
    );
`else
    modport master (
        output tpu_control, int_clr,
        input  counter, slot_start, frame_wrap, int_flag, tpu_irq
    );
    modport slave (
        input  tpu_control, int_clr,
        output counter, slot_start, frame_wrap, int_flag, tpu_irq
    );
`endif

endinterface

// File: rtl/tpu_slot_timer.sv
// Free-running TDMA frame timer: {slot, tick} counter, strobes and sticky IRQ.
// TPU_SLOT_LIMIT_EN shortens the frame to num_slots+1 slots.
module tpu_slot_timer
    import tpu_timer_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    tpu_slot_timer_if.slave tmr
);

    tmr_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             start_q, start_d;
    logic             wrap_q, wrap_d;
    logic             flag_q, flag_d;
    logic             irq_q;
    logic             rsttpu, run_en, last;

    assign rsttpu = tmr.tpu_control[CTL_RSTTPU];
    assign run_en = tmr.tpu_control[CTL_TXEN] | tmr.tpu_control[CTL_RXEN];

    // Natural 0xFFFF rollover always counts as a frame end.
`ifdef TPU_SLOT_LIMIT_EN
    assign last = (&cnt_q) |
                  ((cnt_q[CNT_W-1:TICK_W] == tmr.num_slots) &&
                   (&cnt_q[TICK_W-1:0]));
`else
    assign last = &cnt_q;
`endif

    assign cnt_inc = last ? '0 : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (rsttpu) begin
            state_d = TMR_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                TMR_IDLE: begin
                    cnt_d = '0;
                    if (run_en) state_d = TMR_RUN;
                end
                TMR_RUN: begin
                    if (run_en) begin
                        cnt_d  = cnt_inc;
                        wrap_d = last;
                    end else begin
                        state_d = TMR_PAUSE;
                    end
                end
                TMR_PAUSE: begin
                    if (run_en) begin
                        state_d = TMR_RUN;
                        cnt_d   = cnt_inc;
                        wrap_d  = last;
                    end
                end
                default: begin
                    state_d = TMR_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        start_d = (state_d == TMR_RUN) && (cnt_d[TICK_W-1:0] == '0);
        // A wrap in the same cycle as a clear wins.
        flag_d  = wrap_d | (flag_q & ~tmr.int_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TMR_IDLE;
            cnt_q   <= '0;
            start_q <= 1'b0;
            wrap_q  <= 1'b0;
            flag_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            wrap_q  <= wrap_d;
            flag_q  <= flag_d;
            irq_q   <= flag_q & tmr.tpu_control[CTL_INTMSK];
        end
    end

    assign tmr.counter    = cnt_q;
    assign tmr.slot_start = start_q;
    assign tmr.frame_wrap = wrap_q;
    assign tmr.int_flag   = flag_q;
    assign tmr.tpu_irq    = irq_q;

endmodule

// File: tb/tb_tpu_slot_timer.sv
// Directed self-checking bench for tpu_slot_timer.
// Exercises the TPU_SLOT_LIMIT_EN variant when that macro is defined.
module tb_tpu_slot_timer;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    tpu_slot_timer_if tif ();

    tpu_slot_timer dut (
        .clk  (clk),
        .reset(reset),
        .tmr  (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tif.tpu_control = 8'h00;
        tif.int_clr = 1'b0;
        step(3);
        checks++;
        if (tif.counter !== 16'h0000) begin
            failures++;
            $display("FAIL reset_counter got=%h exp=0000", tif.counter);
        end
        checks++;
        if ({tif.slot_start, tif.frame_wrap, tif.int_flag, tif.tpu_irq} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000",
                     {tif.slot_start, tif.frame_wrap, tif.int_flag, tif.tpu_irq});
        end
        reset = 1'b0;
        step(2);
        checks++;
        if (tif.counter !== 16'h0000 || tif.slot_start !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold got=%h/%b exp=0000/0", tif.counter, tif.slot_start);
        end
    endtask

    task automatic test_run;
        tif.tpu_control = 8'h02;
        step(1);
        checks++;
        if (tif.counter !== 16'h0000 || tif.slot_start !== 1'b1 || tif.frame_wrap !== 1'b0) begin
            failures++;
            $display("FAIL run_first got=%h/%b/%b exp=0000/1/0",
                     tif.counter, tif.slot_start, tif.frame_wrap);
        end
        step(1);
        checks++;
        if (tif.counter !== 16'h0001 || tif.slot_start !== 1'b0) begin
            failures++;
            $display("FAIL run_second got=%h/%b exp=0001/0", tif.counter, tif.slot_start);
        end
        step(16'h01FF);
        checks++;
        if (tif.counter !== 16'h0200 || tif.slot_start !== 1'b1) begin
            failures++;
            $display("FAIL slot1_start got=%h/%b exp=0200/1", tif.counter, tif.slot_start);
        end
        step(16'h0200);
        checks++;
        if (tif.counter !== 16'h0400 || tif.slot_start !== 1'b1) begin
            failures++;
            $display("FAIL slot2_start got=%h/%b exp=0400/1", tif.counter, tif.slot_start);
        end
        tif.tpu_control = 8'h0A;
    endtask

    task automatic test_wrap;
        step(16'hFBFF);
        checks++;
        if (tif.counter !== 16'hFFFF || tif.frame_wrap !== 1'b0 || tif.int_flag !== 1'b0) begin
            failures++;
            $display("FAIL pre_wrap got=%h/%b/%b exp=ffff/0/0",
                     tif.counter, tif.frame_wrap, tif.int_flag);
        end
        tif.int_clr = 1'b1;
        step(1);
        tif.int_clr = 1'b0;
        checks++;
        if (tif.counter !== 16'h0000 || tif.frame_wrap !== 1'b1) begin
            failures++;
            $display("FAIL wrap got=%h/%b exp=0000/1", tif.counter, tif.frame_wrap);
        end
        checks++;
        if (tif.int_flag !== 1'b1 || tif.tpu_irq !== 1'b0 || tif.slot_start !== 1'b1) begin
            failures++;
            $display("FAIL wrap_flag_set_wins got=%b/%b/%b exp=1/0/1",
                     tif.int_flag, tif.tpu_irq, tif.slot_start);
        end
        step(1);
        checks++;
        if (tif.counter !== 16'h0001 || tif.frame_wrap !== 1'b0 ||
            tif.int_flag !== 1'b1 || tif.tpu_irq !== 1'b1) begin
            failures++;
            $display("FAIL post_wrap_irq got=%h/%b/%b/%b exp=0001/0/1/1",
                     tif.counter, tif.frame_wrap, tif.int_flag, tif.tpu_irq);
        end
    endtask

    task automatic test_pause;
        step(16'h0122);
        tif.tpu_control = 8'h08;
        step(1);
        checks++;
        if (tif.counter !== 16'h0123 || tif.slot_start !== 1'b0) begin
            failures++;
            $display("FAIL pause_enter got=%h/%b exp=0123/0", tif.counter, tif.slot_start);
        end
        step(3);
        checks++;
        if (tif.counter !== 16'h0123 || tif.frame_wrap !== 1'b0) begin
            failures++;
            $display("FAIL pause_hold got=%h/%b exp=0123/0", tif.counter, tif.frame_wrap);
        end
        tif.tpu_control = 8'h0C;
        step(1);
        checks++;
        if (tif.counter !== 16'h0124 || tif.int_flag !== 1'b1) begin
            failures++;
            $display("FAIL resume got=%h/%b exp=0124/1", tif.counter, tif.int_flag);
        end
    endtask

    task automatic test_rsttpu;
        step(16'h4443);
        checks++;
        if (tif.counter !== 16'h4567) begin
            failures++;
            $display("FAIL reach_4567 got=%h exp=4567", tif.counter);
        end
        tif.tpu_control = 8'h0D;
        step(1);
        checks++;
        if (tif.counter !== 16'h0000 || tif.int_flag !== 1'b1 ||
            tif.slot_start !== 1'b0 || tif.frame_wrap !== 1'b0) begin
            failures++;
            $display("FAIL rsttpu got=%h/%b/%b/%b exp=0000/1/0/0",
                     tif.counter, tif.int_flag, tif.slot_start, tif.frame_wrap);
        end
        tif.tpu_control = 8'h0C;
        step(1);
        checks++;
        if (tif.counter !== 16'h0000 || tif.slot_start !== 1'b1) begin
            failures++;
            $display("FAIL restart got=%h/%b exp=0000/1", tif.counter, tif.slot_start);
        end
        step(1);
        checks++;
        if (tif.counter !== 16'h0001) begin
            failures++;
            $display("FAIL restart_count got=%h exp=0001", tif.counter);
        end
    endtask

    task automatic test_int_clr;
        tif.int_clr = 1'b1;
        step(1);
        tif.int_clr = 1'b0;
        checks++;
        if (tif.int_flag !== 1'b0 || tif.tpu_irq !== 1'b1) begin
            failures++;
            $display("FAIL int_clr got=%b/%b exp=0/1", tif.int_flag, tif.tpu_irq);
        end
        step(1);
        checks++;
        if (tif.tpu_irq !== 1'b0 || tif.counter !== 16'h0003) begin
            failures++;
            $display("FAIL irq_drop got=%b/%h exp=0/0003", tif.tpu_irq, tif.counter);
        end
    endtask

    task automatic test_pause_tick0;
        step(16'h01FD);
        checks++;
        if (tif.counter !== 16'h0200 || tif.slot_start !== 1'b1) begin
            failures++;
            $display("FAIL tick0_reach got=%h/%b exp=0200/1", tif.counter, tif.slot_start);
        end
        tif.tpu_control = 8'h08;
        step(1);
        checks++;
        if (tif.counter !== 16'h0200 || tif.slot_start !== 1'b0) begin
            failures++;
            $display("FAIL tick0_pause got=%h/%b exp=0200/0", tif.counter, tif.slot_start);
        end
        tif.tpu_control = 8'h0C;
        step(1);
        checks++;
        if (tif.counter !== 16'h0201 || tif.slot_start !== 1'b0) begin
            failures++;
            $display("FAIL tick0_resume got=%h/%b exp=0201/0", tif.counter, tif.slot_start);
        end
    endtask

    task automatic test_mid_reset;
        reset = 1'b1;
        step(1);
        checks++;
        if (tif.counter !== 16'h0000 ||
            {tif.slot_start, tif.frame_wrap, tif.int_flag, tif.tpu_irq} !== 4'b0000) begin
            failures++;
            $display("FAIL mid_reset got=%h/%b exp=0000/0000", tif.counter,
                     {tif.slot_start, tif.frame_wrap, tif.int_flag, tif.tpu_irq});
        end
        reset = 1'b0;
        tif.tpu_control = 8'h00;
        step(2);
        checks++;
        if (tif.counter !== 16'h0000) begin
            failures++;
            $display("FAIL post_reset_idle got=%h exp=0000", tif.counter);
        end
    endtask

`ifdef TPU_SLOT_LIMIT_EN
    task automatic test_slot_limit;
        tif.num_slots = 7'd2;
        tif.tpu_control = 8'h02;
        step(1);
        checks++;
        if (tif.counter !== 16'h0000 || tif.slot_start !== 1'b1) begin
            failures++;
            $display("FAIL lim_start got=%h/%b exp=0000/1", tif.counter, tif.slot_start);
        end
        step(16'h05FF);
        checks++;
        if (tif.counter !== 16'h05FF || tif.frame_wrap !== 1'b0) begin
            failures++;
            $display("FAIL lim_last got=%h/%b exp=05ff/0", tif.counter, tif.frame_wrap);
        end
        step(1);
        checks++;
        if (tif.counter !== 16'h0000 || tif.frame_wrap !== 1'b1 || tif.int_flag !== 1'b1) begin
            failures++;
            $display("FAIL lim_wrap got=%h/%b/%b exp=0000/1/1",
                     tif.counter, tif.frame_wrap, tif.int_flag);
        end
        tif.num_slots = 7'd0;
        step(16'h01FF);
        checks++;
        if (tif.counter !== 16'h01FF || tif.frame_wrap !== 1'b0) begin
            failures++;
            $display("FAIL one_slot_last got=%h/%b exp=01ff/0", tif.counter, tif.frame_wrap);
        end
        step(1);
        checks++;
        if (tif.counter !== 16'h0000 || tif.frame_wrap !== 1'b1) begin
            failures++;
            $display("FAIL one_slot_wrap got=%h/%b exp=0000/1", tif.counter, tif.frame_wrap);
        end
        tif.tpu_control = 8'h00;
        tif.num_slots = 7'h7F;
        step(1);
    endtask
`endif

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        tif.tpu_control = 8'h00;
        tif.int_clr = 1'b0;
`ifdef TPU_SLOT_LIMIT_EN
        tif.num_slots = 7'h7F;
`endif
        test_reset;
        test_run;
        test_wrap;
        test_pause;
        test_rsttpu;
        test_int_clr;
        test_pause_tick0;
        test_mid_reset;
`ifdef TPU_SLOT_LIMIT_EN
        test_slot_limit;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
